// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types, RV32I field encodings and ALU codes for the control FSM
package multicycle_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int ALU_W  = 4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [WORD_W-1:0] EBREAK_WORD = 32'h0010_0073;

  // Encodings shared with the datapath ALU
  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_t;

  typedef enum logic [2:0] {
    CLS_OP,
    CLS_OPIMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_EBREAK
  } instr_class_t;

  function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] make_imm(input logic [WORD_W-1:0] ir, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:   return {{20{ir[31]}}, ir[31:20]};
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction and data memory handshake bundle
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic              imem_req;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;
  logic              dmem_req;
  logic              memWrite;
  logic              dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output memWrite,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  memWrite,
    output dmem_ack
  );

endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// rtl/multicycle_ctrl_decoder.sv - combinational IR decode into ALU op, immediate, class and legality
module multicycle_ctrl_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] ir,
  output logic [ALU_W-1:0]  alu_ctrl,
  output logic [WORD_W-1:0] imm,
  output logic              alu_src_imm,
  output instr_class_t      cls,
  output logic              legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_fmt_t   fmt;
  alu_op_t    alu_op;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // Classify the opcode; only the RV32I subset the FSM can sequence counts as legal
  always_comb begin
    cls         = CLS_OP;
    legal       = 1'b0;
    fmt         = IMM_NONE;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        cls    = CLS_OP;
        alu_op = alu_from_funct(funct3, funct7[5]);
        legal  = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      OPC_OPIMM: begin
        cls         = CLS_OPIMM;
        fmt         = IMM_I;
        alu_src_imm = 1'b1;
        // bit 30 only selects SRAI; for ADDI etc. it is just part of the immediate
        alu_op      = alu_from_funct(funct3, (funct3 == F3_SR) && funct7[5]);
        if (funct3 == F3_SLL)
          legal = (funct7 == F7_BASE);
        else if (funct3 == F3_SR)
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else
          legal = 1'b1;
      end
      OPC_LOAD: begin
        cls         = CLS_LOAD;
        fmt         = IMM_I;
        alu_src_imm = 1'b1;
        legal       = (funct3 == F3_WORD);
      end
      OPC_STORE: begin
        cls         = CLS_STORE;
        fmt         = IMM_S;
        alu_src_imm = 1'b1;
        legal       = (funct3 == F3_WORD);
      end
      OPC_BRANCH: begin
        cls    = CLS_BRANCH;
        fmt    = IMM_B;
        alu_op = ALU_SUB;
        legal  = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      end
      OPC_SYSTEM: begin
        cls   = CLS_EBREAK;
        legal = (ir == EBREAK_WORD);
      end
      default: legal = 1'b0;
    endcase
  end

  assign imm      = make_imm(ir, fmt);
  assign alu_ctrl = alu_op;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM sequencing fetch, decode, execute, memory and writeback
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 256,
  parameter int INSTRET_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    mem,
  output logic                 regWrite,
  output logic [REG_W-1:0]     rs1,
  output logic [REG_W-1:0]     rs2,
  output logic [REG_W-1:0]     rd,
  output logic [ALU_W-1:0]     ALUControl,
  output logic                 aluSrcImm,
  output logic [WORD_W-1:0]    imm,
  output logic                 wbSel,
  input  logic                 zero,
  output logic                 pcWrite,
  output logic                 pcSel,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout,
  output logic [INSTRET_W-1:0] instret
);

  // Counter only needs to hold WAIT_TIMEOUT-1, the last waiting cycle before giving up
  localparam int WCNT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_TIMEOUT - 1);

  state_t            state, state_next;
  logic [WORD_W-1:0] ir;
  logic [WCNT_W-1:0] wait_cnt;
  instr_class_t      cls;
  logic              legal;
  logic              wait_hit;
  logic              imem_req_s;
  logic              dmem_req_s;
  logic              mem_write_s;
  logic              set_illegal;
  logic              set_timeout;

  multicycle_ctrl_decoder u_decoder (
    .ir          (ir),
    .alu_ctrl    (ALUControl),
    .imm         (imm),
    .alu_src_imm (aluSrcImm),
    .cls         (cls),
    .legal       (legal)
  );

  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rd       = ir[11:7];
  assign halted   = (state == S_HALT);
  assign wait_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  // Reset is folded into the fetch request so it drops the moment reset asserts
  assign mem.imem_req = imem_req_s & reset;
  assign mem.dmem_req = dmem_req_s;
  assign mem.memWrite = mem_write_s;

  // Next-state and per-state enables; acks are only looked at in the state that requested
  always_comb begin
    state_next  = state;
    imem_req_s  = 1'b0;
    dmem_req_s  = 1'b0;
    mem_write_s = 1'b0;
    regWrite    = 1'b0;
    wbSel       = 1'b0;
    pcWrite     = 1'b0;
    pcSel       = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (mem.imem_ack) begin
          state_next = S_DECODE;
        end else if (wait_hit) begin
          state_next  = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_next  = S_HALT;
          set_illegal = 1'b1;
        end else if (cls == CLS_EBREAK) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          CLS_OP, CLS_OPIMM:   state_next = S_WB;
          CLS_LOAD, CLS_STORE: state_next = S_MEM;
          CLS_BRANCH: begin
            pcWrite    = 1'b1;
            pcSel      = (ir[14:12] == F3_BEQ) ? zero : ~zero;
            state_next = S_FETCH;
          end
          default: state_next = S_HALT;
        endcase
      end
      S_MEM: begin
        dmem_req_s  = 1'b1;
        mem_write_s = (cls == CLS_STORE);
        if (mem.dmem_ack) begin
          if (cls == CLS_STORE) begin
            pcWrite    = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_hit) begin
          state_next  = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_WB: begin
        regWrite   = (rd != '0);
        wbSel      = (cls == CLS_LOAD);
        pcWrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  // State register, IR capture, wait counter, retire counter and sticky halt causes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == S_FETCH) && mem.imem_ack)
        ir <= mem.imem_rdata;
      if (state_next != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH) || (state == S_MEM))
        wait_cnt <= wait_cnt + 1'b1;
      if (pcWrite)
        instret <= instret + 1'b1;
      if (set_illegal)
        illegal <= 1'b1;
      if (set_timeout)
        timeout <= 1'b1;
    end
  end

endmodule
